// File: rtl/jb_oran_lphy_stat_cnt_if.sv
// rtl/jb_oran_lphy_stat_cnt_if.sv - event/snapshot/sticky bus between the ORAN parser and the statistics counter bank
interface jb_oran_lphy_stat_cnt_if #(
   parameter int NUM_CNT  = 25,
   parameter int CNT_W    = 32,
   parameter int STICKY_W = 57
);
   logic [NUM_CNT-1:0]       evt_i;
   logic                     evt_en_i;
   logic                     snap_req_i;
   logic                     snap_done_o;
   logic [NUM_CNT*CNT_W-1:0] cnt_o;
   logic [STICKY_W-1:0]      sticky_i;
   logic [STICKY_W-1:0]      sticky_clr_i;
   logic [STICKY_W-1:0]      sticky_o;
   logic [NUM_CNT-1:0]       ovf_o;

   modport master (
      output evt_i, evt_en_i, snap_req_i, sticky_i, sticky_clr_i,
      input  snap_done_o, cnt_o, sticky_o, ovf_o
   );

   modport slave (
      input  evt_i, evt_en_i, snap_req_i, sticky_i, sticky_clr_i,
      output snap_done_o, cnt_o, sticky_o, ovf_o
   );
endinterface

// File: rtl/jb_oran_lphy_stat_cnt.sv
// rtl/jb_oran_lphy_stat_cnt.sv - ORAN LPHY statistics counter bank with coherent snapshot and sticky flags
// Define JB_ORAN_LPHY_STAT_CNT_SAT_EN for saturating counters; the default build wraps.
module jb_oran_lphy_stat_cnt #(
   parameter int NUM_CNT     = 25,
   parameter int CNT_W       = 32,
   parameter int STICKY_W    = 57,
   parameter int CLR_ON_SNAP = 1
) (
   input logic                   clk,
   input logic                   rst,
   jb_oran_lphy_stat_cnt_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NUM_CNT-1:0]  inc;
   logic [NUM_CNT-1:0]  ovf;
   logic [STICKY_W-1:0] sticky;
   logic                snap_done;

   assign inc = bus.evt_en_i ? bus.evt_i : '0;

   for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
      logic [CNT_W-1:0] live_r;
      logic [CNT_W-1:0] shadow_r;
      logic [CNT_W-1:0] live_nxt;
      logic [CNT_W-1:0] inc_term;
      logic             at_max;
      logic             ovf_r;

      assign at_max   = (live_r == CNT_MAX);
      assign inc_term = {{(CNT_W-1){1'b0}}, inc[k]};
`ifdef JB_ORAN_LPHY_STAT_CNT_SAT_EN
      assign live_nxt = (inc[k] && !at_max) ? live_r + 1'b1 : live_r;
`else
      assign live_nxt = live_r + inc_term;
`endif

      // On a clearing snapshot the live counter restarts from this cycle's event, so nothing is lost.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            live_r   <= '0;
            shadow_r <= '0;
            ovf_r    <= 1'b0;
         end else if (bus.snap_req_i && (CLR_ON_SNAP != 0)) begin
            shadow_r <= live_r;
            live_r   <= inc_term;
            ovf_r    <= 1'b0;
         end else begin
            if (bus.snap_req_i) begin
               shadow_r <= live_r;
            end
            live_r <= live_nxt;
            ovf_r  <= ovf_r | (inc[k] & at_max);
         end
      end

      assign ovf[k]                      = ovf_r;
      assign bus.cnt_o[k*CNT_W +: CNT_W] = shadow_r;
   end

   // Set dominates clear so a flag raised in the clearing cycle survives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky    <= '0;
         snap_done <= 1'b0;
      end else begin
         sticky    <= (sticky & ~bus.sticky_clr_i) | bus.sticky_i;
         snap_done <= bus.snap_req_i;
      end
   end

   assign bus.sticky_o    = sticky;
   assign bus.snap_done_o = snap_done;
   assign bus.ovf_o       = ovf;

endmodule

// File: tb/tb_jb_oran_lphy_stat_cnt.sv
// tb/tb_jb_oran_lphy_stat_cnt.sv - directed scoreboard bench for the statistics counter bank
module tb_jb_oran_lphy_stat_cnt;
   localparam int BW = 25 * 32;
   localparam int SW = 4 * 4;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [BW-1:0] exp_q [$];
   logic [SW-1:0] exp_s_q [$];

   jb_oran_lphy_stat_cnt_if #(.NUM_CNT(25), .CNT_W(32), .STICKY_W(57)) b ();
   jb_oran_lphy_stat_cnt_if #(.NUM_CNT(4), .CNT_W(4), .STICKY_W(8)) s ();

   jb_oran_lphy_stat_cnt #(.NUM_CNT(25), .CNT_W(32), .STICKY_W(57), .CLR_ON_SNAP(1)) dut_big (
      .clk (clk),
      .rst (rst),
      .bus (b)
   );

   jb_oran_lphy_stat_cnt #(.NUM_CNT(4), .CNT_W(4), .STICKY_W(8), .CLR_ON_SNAP(0)) dut_small (
      .clk (clk),
      .rst (rst),
      .bus (s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pop_big(input string tag);
      logic [BW-1:0] e;
      chk({tag, "_done"}, BW'(b.snap_done_o), BW'(1));
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed empty scoreboard expected entry", tag);
      end else begin
         e = exp_q.pop_front();
         chk(tag, b.cnt_o, e);
      end
   endtask

   task automatic pop_small(input string tag);
      logic [SW-1:0] e;
      chk({tag, "_done"}, BW'(s.snap_done_o), BW'(1));
      if (exp_s_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed empty scoreboard expected entry", tag);
      end else begin
         e = exp_s_q.pop_front();
         chk(tag, BW'(s.cnt_o), BW'(e));
      end
   endtask

   initial begin
      logic [BW-1:0] e;
      logic [SW-1:0] es;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      b.evt_i = '0; b.evt_en_i = 1'b0; b.snap_req_i = 1'b0; b.sticky_i = '0; b.sticky_clr_i = '0;
      s.evt_i = '0; s.evt_en_i = 1'b0; s.snap_req_i = 1'b0; s.sticky_i = '0; s.sticky_clr_i = '0;
      tick();
      tick();
      chk("rst_cnt", b.cnt_o, '0);
      chk("rst_done", BW'(b.snap_done_o), '0);
      chk("rst_ovf", BW'(b.ovf_o), '0);
      chk("rst_sticky", BW'(b.sticky_o), '0);
      #2 rst = 1'b0;
      tick();

      // ten events on counter 3, then snapshot
      b.evt_en_i = 1'b1;
      b.evt_i = 25'd1 << 3;
      for (int i = 0; i < 10; i++) tick();
      b.evt_i = '0;
      b.snap_req_i = 1'b1;
      e = '0; e[3*32 +: 32] = 32'd10; exp_q.push_back(e);
      tick();
      b.snap_req_i = 1'b0;
      pop_big("snap_ten");
      tick();
      chk("done_one_cycle", BW'(b.snap_done_o), '0);
      chk("cnt_hold", b.cnt_o[3*32 +: 32], BW'(10));
      b.snap_req_i = 1'b1;
      exp_q.push_back('0);
      tick();
      b.snap_req_i = 1'b0;
      pop_big("snap_cleared");

      // event coincident with snapshot
      b.evt_i = 25'd1;
      for (int i = 0; i < 5; i++) tick();
      b.snap_req_i = 1'b1;
      e = '0; e[31:0] = 32'd5; exp_q.push_back(e);
      tick();
      b.snap_req_i = 1'b0;
      b.evt_i = '0;
      pop_big("snap_coincident");
      tick();
      b.snap_req_i = 1'b1;
      e = '0; e[31:0] = 32'd1; exp_q.push_back(e);
      tick();
      b.snap_req_i = 1'b0;
      pop_big("snap_carry_one");

      // global enable low
      b.evt_en_i = 1'b0;
      b.evt_i = '1;
      for (int i = 0; i < 100; i++) tick();
      b.snap_req_i = 1'b1;
      exp_q.push_back('0);
      tick();
      b.snap_req_i = 1'b0;
      b.evt_i = '0;
      b.evt_en_i = 1'b1;
      pop_big("snap_disabled");
      chk("ovf_none", BW'(b.ovf_o), '0);

      // back-to-back snapshots
      b.evt_i = 25'd1 << 1;
      for (int i = 0; i < 3; i++) tick();
      b.snap_req_i = 1'b1;
      e = '0; e[1*32 +: 32] = 32'd3; exp_q.push_back(e);
      e = '0; e[1*32 +: 32] = 32'd1; exp_q.push_back(e);
      tick();
      pop_big("b2b_first");
      tick();
      pop_big("b2b_second");
      b.snap_req_i = 1'b0;
      b.evt_i = '0;
      tick();
      chk("b2b_done_low", BW'(b.snap_done_o), '0);

      // small wrap/saturate build, non-clearing snapshots
      s.evt_en_i = 1'b1;
      s.evt_i = 4'b0001;
      for (int i = 0; i < 5; i++) tick();
      s.snap_req_i = 1'b1;
      exp_s_q.push_back(16'h0005);
      tick();
      s.snap_req_i = 1'b0;
      s.evt_i = '0;
      pop_small("small_coincident");
      tick();
      s.snap_req_i = 1'b1;
      exp_s_q.push_back(16'h0006);
      tick();
      s.snap_req_i = 1'b0;
      pop_small("small_noclear");
      s.evt_i = 4'b0100;
      for (int i = 0; i < 17; i++) tick();
      s.evt_i = '0;
      s.snap_req_i = 1'b1;
`ifdef JB_ORAN_LPHY_STAT_CNT_SAT_EN
      es = 16'h0F06;
`else
      es = 16'h0106;
`endif
      exp_s_q.push_back(es);
      tick();
      s.snap_req_i = 1'b0;
      pop_small("small_ovf_cnt");
      chk("small_ovf_flag", BW'(s.ovf_o), BW'(4'b0100));
      tick();
      chk("small_ovf_sticky", BW'(s.ovf_o), BW'(4'b0100));

      // sticky flags
      b.sticky_i = 57'd1 << 5;
      tick();
      b.sticky_i = 57'd1 << 56;
      tick();
      b.sticky_i = '0;
      chk("sticky_set", BW'(b.sticky_o), BW'((57'd1 << 5) | (57'd1 << 56)));
      b.sticky_clr_i = 57'd1 << 5;
      tick();
      b.sticky_clr_i = '0;
      chk("sticky_clr", BW'(b.sticky_o), BW'(57'd1 << 56));
      b.sticky_i = 57'd1 << 5;
      tick();
      b.sticky_clr_i = (57'd1 << 5) | (57'd1 << 56);
      tick();
      b.sticky_i = '0;
      b.sticky_clr_i = '0;
      chk("sticky_set_wins", BW'(b.sticky_o), BW'(57'd1 << 5));

      // asynchronous reset with a snapshot pending
      b.evt_i = '1;
      b.snap_req_i = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("arst_cnt", b.cnt_o, '0);
      chk("arst_sticky", BW'(b.sticky_o), '0);
      chk("arst_done", BW'(b.snap_done_o), '0);
      chk("arst_small_ovf", BW'(s.ovf_o), '0);
      tick();
      b.snap_req_i = 1'b0;
      b.evt_i = '0;
      #2 rst = 1'b0;
      tick();
      chk("arst_no_done", BW'(b.snap_done_o), '0);
      tick();
      chk("arst_no_done2", BW'(b.snap_done_o), '0);
      chk("arst_cnt_after", b.cnt_o, '0);
      chk("scoreboard_empty", BW'(exp_q.size() + exp_s_q.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/jb_oran_lphy_stat_cnt.md
Name: jb_oran_lphy_stat_cnt

Overview:
- Event-counter bank that drives the ORAN LPHY statistics counters (runt type0/type2, window t0/t2/t3, other-error, t1/t3 ctrl/data/reqs per UL stream).
- Takes single-cycle event pulses from the ORAN C/U-plane parser and produces the 32-bit count values consumed by the statistics interface's counter-output modport.
- Also captures sticky error flags (vld_wo_rdy, fifo overflow, stale reqs/prbs) for register readback.
- Counts are coherent: a snapshot request copies all live counters into shadow registers in one cycle, and software reads the shadows.

Parameters:
- NUM_CNT, 25, number of event counters; the default matches the 25 counter fields of the statistics interface.
- CNT_W, 32, width of each counter.
- STICKY_W, 57, number of sticky flag inputs: 16+16+16+16 UL flags is 64 bits. The default is the consumer's chosen subset; the width is fully parameterisable.
- CLR_ON_SNAP, 1, when 1 a snapshot also zeroes the live counters.

Ports:
- clk  input  1  block clock, shared with the ORAN parser.
- rst  input  1  asynchronous, active-high reset.
- evt_i  input  NUM_CNT  per-counter increment pulse; bit k high means counter k increments by 1 this cycle.
- evt_en_i  input  1  global count enable; when low, evt_i is ignored.
- snap_req_i  input  1  single-cycle snapshot request.
- snap_done_o  output  1  single-cycle pulse one cycle after an accepted snapshot.
- cnt_o  output  NUM_CNT*CNT_W  shadow counter values; counter k occupies bits [k*CNT_W +: CNT_W].
- sticky_i  input  STICKY_W  level or pulse error flags.
- sticky_clr_i  input  STICKY_W  write-1-to-clear mask for the sticky flags.
- sticky_o  output  STICKY_W  latched sticky flags.
- ovf_o  output  NUM_CNT  per-counter overflow indicator for the current period.

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled externally): all live counters, shadows, cnt_o, sticky_o, ovf_o and snap_done_o are 0.
- Live counter k, each cycle with evt_en_i=1 and evt_i[k]=1: live[k] <= live[k]+1. Width is exactly CNT_W; at the all-ones value the behaviour follows the optional feature.
- Snapshot is accepted on any cycle snap_req_i=1 and completes in that cycle:
  - shadow[k] <= live[k] value before this cycle's increment; cnt_o reflects it the next cycle.
  - If CLR_ON_SNAP=1: live[k] <= evt term only, i.e. 1 if counting this cycle, else 0, so no event is lost or double-counted. ovf_o is cleared, and an overflow in that same cycle cannot occur since the new value is ≤1.
  - If CLR_ON_SNAP=0: live counters continue normally.
  - snap_done_o = 1 exactly one cycle after an accepted snap_req_i.
- Back-to-back snapshots on consecutive cycles are both accepted. The second shadow holds the events of one cycle only, when CLR_ON_SNAP=1.
- Latency: event to live counter is 1 cycle; snapshot to cnt_o and snap_done_o is 1 cycle. cnt_o changes only on a snapshot.
- Sticky flags: sticky_o[i] <= (sticky_o[i] & ~sticky_clr_i[i]) | sticky_i[i]. Set wins over a simultaneous clear, so an event is never lost.
- ovf_o[k] is set when live[k] is all-ones and increments. It clears on reset, or on a snapshot when CLR_ON_SNAP=1; otherwise it is sticky until reset.
- Reset mid-operation: all state returns to 0 immediately, and any pending snap_done_o is dropped.
- Implementation is pure flops plus per-counter adders; no RAM is used.

Optional Feature:
- JB_ORAN_LPHY_STAT_CNT_SAT_EN defined: counters saturate at 2^CNT_W-1 and hold there until cleared. ovf_o[k] still sets on the attempted increment.
- Macro undefined: counters wrap from all-ones to 0, and ovf_o[k] sets on the wrap.
- The snapshot and clear semantics are identical in both builds.

Test Plan:
- Reset, then pulse evt_i[3] 10 times and snap_req_i once -> cnt_o[3] = 10 and all other counters = 0. snap_done_o is high one cycle after the request. With CLR_ON_SNAP=1, live[3] reads 0 at the next snapshot.
- evt_i[0]=1 in the same cycle as snap_req_i, after 5 prior events -> shadow[0] = 5. The next snapshot with no further events gives 1 (CLR_ON_SNAP=1) or 6 (CLR_ON_SNAP=0).
- evt_en_i=0 while evt_i is all ones for 100 cycles, then a snapshot -> all cnt_o = 0.
- CNT_W=4 build, 17 events on counter 2, then a snapshot:
  - with _SAT_EN: cnt_o[2] = 15 and ovf_o[2] = 1.
  - without _SAT_EN: cnt_o[2] = 1 and ovf_o[2] = 1.
- Sticky: sticky_i[5] pulsed, then sticky_clr_i[5] -> bit 5 is cleared. With sticky_i[5] and sticky_clr_i[5] high in the same cycle, sticky_o[5] stays 1.
- Assert rst asynchronously mid-count with snap_req_i high -> all outputs are 0 in that cycle and no snap_done_o appears after release.
